// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: word type, memory arbiter state encoding and arbiter defaults.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_IACC = 2'd1,
      ARB_DACC = 2'd2
   } arb_state_t;

   localparam int unsigned ARB_STARVE_LIMIT_DEFAULT = 4;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating 4-bit count of data grants made while a fetch waits; flags when LIMIT is reached.
module arb_starve_ctr
   import cpu_types_pkg::*;
#(
   parameter int unsigned LIMIT = ARB_STARVE_LIMIT_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic at_limit
);

   logic [3:0] count_q, count_d;

   // Clear wins over increment; the count sticks at 15 rather than wrapping.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = 4'd0;
      end else if (inc && (count_q != 4'hF)) begin
         count_d = count_q + 4'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= 4'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign at_limit = (count_q == 4'(LIMIT));

endmodule

// File: rtl/memory_arbiter.sv
// Serialises instruction fetches and data accesses onto one RAM port, data first.
// Optional fetch starvation guard: define MEM_ARB_STARVE_GUARD_EN.
module memory_arbiter
   import cpu_types_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = ARB_STARVE_LIMIT_DEFAULT
) (
   input  logic  CLK,
   input  logic  RST,
   input  logic  iREN,
   input  word_t iaddr,
   input  logic  dREN,
   input  logic  dWEN,
   input  word_t daddr,
   input  word_t dstore,
   output logic  iwait,
   output logic  dwait,
   output word_t iload,
   output word_t dload,
   output logic  ram_ren,
   output logic  ram_wen,
   output word_t ram_addr,
   output word_t ram_wdata,
   input  word_t ram_rdata,
   input  logic  ram_ready
);

   if ((STARVE_LIMIT == 0) || (STARVE_LIMIT > 15)) begin : g_bad_limit
      $error("memory_arbiter: STARVE_LIMIT must be within 1..15");
   end

   arb_state_t state_q, state_d;
   word_t      addr_q, addr_d;
   word_t      wdata_q, wdata_d;
   logic       wr_q, wr_d;
   word_t      iload_q, dload_q;

   logic data_req, in_idle, force_i, grant_d, grant_i;
   logic i_done, d_done;

   assign data_req = dREN | dWEN;
   assign in_idle  = (state_q == ARB_IDLE);

`ifdef MEM_ARB_STARVE_GUARD_EN
   logic at_limit;

   arb_starve_ctr #(
      .LIMIT (STARVE_LIMIT)
   ) u_starve_ctr (
      .clk      (CLK),
      .rst      (RST),
      .inc      (grant_d && iREN),
      .clr      (grant_i || (in_idle && !iREN)),
      .at_limit (at_limit)
   );

   assign force_i = at_limit && iREN;
`else
   assign force_i = 1'b0;
`endif

   assign grant_d = in_idle && data_req && !force_i;
   assign grant_i = in_idle && iREN && (!data_req || force_i);

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wr_d    = wr_q;
      unique case (state_q)
         ARB_IDLE: begin
            if (grant_d) begin
               state_d = ARB_DACC;
               addr_d  = daddr;
               wdata_d = dstore;
               wr_d    = dWEN;
            end else if (grant_i) begin
               state_d = ARB_IACC;
               addr_d  = iaddr;
               wr_d    = 1'b0;
            end
         end
         ARB_IACC, ARB_DACC: begin
            if (ram_ready) begin
               state_d = ARB_IDLE;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   // Completion only counts while the requester still asks; a dropped request is discarded.
   assign i_done = (state_q == ARB_IACC) && ram_ready && iREN;
   assign d_done = (state_q == ARB_DACC) && ram_ready && data_req;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= ARB_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         wr_q    <= 1'b0;
         iload_q <= '0;
         dload_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wr_q    <= wr_d;
         if (i_done) iload_q <= ram_rdata;
         if (d_done) dload_q <= ram_rdata;
      end
   end

   assign ram_ren   = (state_q == ARB_IACC) || ((state_q == ARB_DACC) && !wr_q);
   assign ram_wen   = (state_q == ARB_DACC) && wr_q;
   assign ram_addr  = addr_q;
   assign ram_wdata = wdata_q;

   assign iwait = !i_done;
   assign dwait = !d_done;
   assign iload = i_done ? ram_rdata : iload_q;
   assign dload = d_done ? ram_rdata : dload_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a latency-programmable RAM model and a completion scoreboard.
// Grant-order step depends on MEM_ARB_STARVE_GUARD_EN.
module tb_memory_arbiter;
   import cpu_types_pkg::*;

   logic  CLK = 1'b0;
   logic  RST;
   logic  iREN, dREN, dWEN;
   word_t iaddr, daddr, dstore;
   logic  iwait, dwait, ram_ren, ram_wen, ram_ready;
   word_t iload, dload, ram_addr, ram_wdata, ram_rdata;

   int tests = 0;
   int fails = 0;
   int lat   = 1;
   int rcnt;

   typedef struct packed {
      logic  src_i;
      word_t val;
   } exp_t;
   exp_t sb[$];

   always #5 CLK = ~CLK;

   memory_arbiter #(
      .STARVE_LIMIT (2)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .iREN      (iREN),
      .iaddr     (iaddr),
      .dREN      (dREN),
      .dWEN      (dWEN),
      .daddr     (daddr),
      .dstore    (dstore),
      .iwait     (iwait),
      .dwait     (dwait),
      .iload     (iload),
      .dload     (dload),
      .ram_ren   (ram_ren),
      .ram_wen   (ram_wen),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata),
      .ram_ready (ram_ready)
   );

   function automatic word_t ram_fn(input word_t a);
      if (a == 32'h40) return 32'h8C22_0004;
      return a ^ 32'hA5A5_0000;
   endfunction

   // RAM model: ready on the lat-th consecutive strobe cycle.
   always @(posedge CLK or posedge RST) begin
      if (RST) rcnt <= 0;
      else if (ram_ren || ram_wen) rcnt <= ram_ready ? 0 : rcnt + 1;
   end
   assign ram_ready = (ram_ren || ram_wen) && (rcnt == lat - 1);
   assign ram_rdata = ram_fn(ram_addr);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      tests++;
      assert (obs === exp_v) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic push(input logic src_i, input word_t a);
      exp_t e;
      e.src_i = src_i;
      e.val   = ram_fn(a);
      sb.push_back(e);
   endtask

   task automatic mon_pop(input logic src_i, input word_t val, input string tag);
      exp_t e;
      tests++;
      assert (sb.size() != 0) else begin
         fails++;
         $error("FAIL %s_unexpected: observed completion %h, expected none queued", tag, val);
      end
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk({tag, "_src"}, {31'd0, src_i}, {31'd0, e.src_i});
         chk({tag, "_val"}, val, e.val);
      end
   endtask

   always @(negedge CLK) begin
      if (!RST && !iwait) mon_pop(1'b1, iload, "iload");
      if (!RST && !dwait) mon_pop(1'b0, dload, "dload");
   end

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_iwait"}, {31'd0, iwait}, 32'd1);
      chk({tag, "_dwait"}, {31'd0, dwait}, 32'd1);
      chk({tag, "_iload"}, iload, 32'd0);
      chk({tag, "_dload"}, dload, 32'd0);
      chk({tag, "_ren"}, {31'd0, ram_ren}, 32'd0);
      chk({tag, "_wen"}, {31'd0, ram_wen}, 32'd0);
      chk({tag, "_addr"}, ram_addr, 32'd0);
      chk({tag, "_wdata"}, ram_wdata, 32'd0);
   endtask

   initial begin
      RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0;
      iaddr = '0; daddr = '0; dstore = '0;
      cyc(); cyc();
      chk_reset_outputs("rst");
      RST = 1'b0;

      // Instruction fetch, latency 3; iaddr change mid-access must be ignored.
      cyc(); lat = 3; iREN = 1; iaddr = 32'h40; push(1'b1, 32'h40); settle();
      chk("if_n_ren", {31'd0, ram_ren}, 32'd0);
      cyc(); iaddr = 32'h44; settle();
      chk("if_n1_ren", {31'd0, ram_ren}, 32'd1);
      chk("if_n1_addr", ram_addr, 32'h40);
      chk("if_n1_iwait", {31'd0, iwait}, 32'd1);
      cyc(); settle();
      chk("if_n2_ren", {31'd0, ram_ren}, 32'd1);
      chk("if_n2_iwait", {31'd0, iwait}, 32'd1);
      cyc(); settle();
      chk("if_n3_ren", {31'd0, ram_ren}, 32'd1);
      chk("if_n3_addr", ram_addr, 32'h40);
      chk("if_n3_iwait", {31'd0, iwait}, 32'd0);
      chk("if_n3_iload", iload, 32'h8C22_0004);
      cyc(); iREN = 0; settle();
      chk("if_n4_ren", {31'd0, ram_ren}, 32'd0);
      chk("if_n4_iload_hold", iload, 32'h8C22_0004);

      // Zero-wait data write.
      cyc(); lat = 1; dWEN = 1; daddr = 32'h100; dstore = 32'hDEAD_BEEF; push(1'b0, 32'h100);
      cyc(); settle();
      chk("wr_wen", {31'd0, ram_wen}, 32'd1);
      chk("wr_ren", {31'd0, ram_ren}, 32'd0);
      chk("wr_addr", ram_addr, 32'h100);
      chk("wr_wdata", ram_wdata, 32'hDEAD_BEEF);
      chk("wr_dwait", {31'd0, dwait}, 32'd0);
      cyc(); dWEN = 0; settle();
      chk("wr_idle_wen", {31'd0, ram_wen}, 32'd0);
      chk("wr_idle_ren", {31'd0, ram_ren}, 32'd0);

      // Simultaneous fetch and read: data first, fetch after one idle turnaround.
      cyc(); iREN = 1; iaddr = 32'h80; dREN = 1; daddr = 32'h200;
      push(1'b0, 32'h200); push(1'b1, 32'h80);
      cyc(); settle();
      chk("pri_d_addr", ram_addr, 32'h200);
      chk("pri_d_dwait", {31'd0, dwait}, 32'd0);
      chk("pri_d_iwait", {31'd0, iwait}, 32'd1);
      cyc(); dREN = 0; settle();
      chk("pri_idle_ren", {31'd0, ram_ren}, 32'd0);
      cyc(); settle();
      chk("pri_i_addr", ram_addr, 32'h80);
      chk("pri_i_iwait", {31'd0, iwait}, 32'd0);
      cyc(); iREN = 0;

      // Read dropped after grant: access completes silently, next request served normally.
      lat = 2; dREN = 1; daddr = 32'h300;
      cyc(); dREN = 0; settle();
      chk("drop_ren", {31'd0, ram_ren}, 32'd1);
      chk("drop_addr", ram_addr, 32'h300);
      chk("drop_dwait1", {31'd0, dwait}, 32'd1);
      cyc(); settle();
      chk("drop_ready", {31'd0, ram_ready}, 32'd1);
      chk("drop_dwait2", {31'd0, dwait}, 32'd1);
      chk("drop_dload_hold", dload, ram_fn(32'h200));
      cyc(); lat = 1; dREN = 1; daddr = 32'h304; push(1'b0, 32'h304); settle();
      chk("drop_idle_ren", {31'd0, ram_ren}, 32'd0);
      cyc(); settle();
      chk("next_addr", ram_addr, 32'h304);
      chk("next_dwait", {31'd0, dwait}, 32'd0);
      chk("next_dload", dload, ram_fn(32'h304));
      cyc(); dREN = 0;

      // Reset in the middle of a data read.
      lat = 3; dREN = 1; daddr = 32'h400;
      cyc(); settle();
      chk("mid_ren", {31'd0, ram_ren}, 32'd1);
      RST = 1'b1; settle();
      chk_reset_outputs("mid_rst");
      cyc(); RST = 1'b0; dREN = 0; settle();
      chk("post_rst_ren", {31'd0, ram_ren}, 32'd0);
      cyc(); settle();
      chk("post_rst_idle", {31'd0, ram_ren | ram_wen}, 32'd0);

      // Both requests held: grant order depends on the starvation guard.
      lat = 1; dREN = 1; daddr = 32'h500; iREN = 1; iaddr = 32'h600;
`ifdef MEM_ARB_STARVE_GUARD_EN
      push(1'b0, 32'h500); push(1'b0, 32'h500); push(1'b1, 32'h600);
      push(1'b0, 32'h500); push(1'b0, 32'h500); push(1'b1, 32'h600);
`else
      push(1'b0, 32'h500); push(1'b0, 32'h500); push(1'b0, 32'h500);
`endif
      for (int c = 0; c < 40 && sb.size() != 0; c++) cyc();
      dREN = 0; iREN = 0;
      cyc(); cyc();
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
